// File: rtl/pixel_writer_if.sv
// Pixel-in and framebuffer-out signal bundle for pixel_writer.
// The slave modport is the pixel_writer view; master is the DPU/framebuffer side.
interface pixel_writer_if;
   logic        px_valid;
   logic [7:0]  px_x;
   logic [7:0]  px_y;
   logic [7:0]  px_colour;
   logic        px_ready;
   logic        fb_req;
   logic [15:0] fb_addr;
   logic [7:0]  fb_data;
   logic        fb_ack;

   modport master (
      output px_valid, px_x, px_y, px_colour, fb_ack,
      input  px_ready, fb_req, fb_addr, fb_data
   );

   modport slave (
      input  px_valid, px_x, px_y, px_colour, fb_ack,
      output px_ready, fb_req, fb_addr, fb_data
   );
endinterface

// File: rtl/pixel_writer.sv
// Buffers DPU pixels in a FIFO and drains them to the framebuffer over a req/ack handshake.
// Build macro PIXEL_WRITER_CLIP_EN drops off-screen pixels instead of wrapping their address.
module pixel_writer #(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned FB_WIDTH  = 160,
   parameter int unsigned FB_HEIGHT = 120
) (
   input  logic          clk,
   input  logic          rst,
   pixel_writer_if.slave bus,
   output logic          busy,
   output logic [7:0]    drop_cnt
);
   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;

   if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
       FB_WIDTH == 0 || FB_HEIGHT == 0) begin : g_bad_params
      $error("pixel_writer: DEPTH must be a power of two in 2..16 and FB sizes non-zero");
   end

   typedef enum logic [0:0] {StIdle, StReq} state_e;

   state_e          state_q, state_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic [7:0]      drop_cnt_q, drop_cnt_d;
   logic            fb_req_q, fb_req_d;
   logic [15:0]     fb_addr_q, fb_addr_d;
   logic [7:0]      fb_data_q, fb_data_d;

   logic [15:0]     mem_addr_q [DEPTH];
   logic [7:0]      mem_data_q [DEPTH];

   logic [15:0]     push_addr;
   logic            clip;
   logic            px_ready;
   logic            push;
   logic            drop;
   logic            pop;

   // Modulo-2^16 arithmetic yields exactly the truncated wide product.
   assign push_addr = 16'(16'(bus.px_y) * 16'(FB_WIDTH) + 16'(bus.px_x));

`ifdef PIXEL_WRITER_CLIP_EN
   assign clip = (32'(bus.px_x) >= FB_WIDTH) || (32'(bus.px_y) >= FB_HEIGHT);
`else
   assign clip = 1'b0;
`endif

   // Readiness uses the pre-pop count, so a full FIFO refuses a push even while popping.
   assign px_ready = (count_q < CntW'(DEPTH));
   assign push     = bus.px_valid && px_ready && !clip;
   assign drop     = bus.px_valid && !(px_ready && !clip);
   assign pop      = (state_q == StReq) && bus.fb_ack;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_addr_q[wr_ptr_q] <= push_addr;
         mem_data_q[wr_ptr_q] <= bus.px_colour;
      end
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      drop_cnt_d = drop_cnt_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end

      unique case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase

      if (drop && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end
   end

   always_comb begin
      state_d   = state_q;
      fb_req_d  = fb_req_q;
      fb_addr_d = fb_addr_q;
      fb_data_d = fb_data_q;

      unique case (state_q)
         StIdle: begin
            if (count_q != '0) begin
               state_d   = StReq;
               fb_req_d  = 1'b1;
               fb_addr_d = mem_addr_q[rd_ptr_q];
               fb_data_d = mem_data_q[rd_ptr_q];
            end
         end
         StReq: begin
            // Head stays in the FIFO until acknowledged; address/data registers hold.
            if (bus.fb_ack) begin
               state_d  = StIdle;
               fb_req_d = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         drop_cnt_q <= '0;
         fb_req_q   <= 1'b0;
         fb_addr_q  <= '0;
         fb_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         drop_cnt_q <= drop_cnt_d;
         fb_req_q   <= fb_req_d;
         fb_addr_q  <= fb_addr_d;
         fb_data_q  <= fb_data_d;
      end
   end

   assign bus.px_ready = px_ready;
   assign bus.fb_req   = fb_req_q;
   assign bus.fb_addr  = fb_addr_q;
   assign bus.fb_data  = fb_data_q;
   assign busy         = (count_q != '0) || (state_q == StReq);
   assign drop_cnt     = drop_cnt_q;
endmodule
